// File: rtl/vram_sequencer.sv
// vram_sequencer: owns the single VRAM port. Scanout reads take strict
// priority every cycle; the host's read / write / clear-screen commands are
// sequenced as RAM accesses on the cycles scanout leaves free.
module vram_sequencer #(
  parameter int          VRAM_WORDS = 2400,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  cmd,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic [15:0] rd_data,
  output logic [1:0]  state,
  input  logic        scan_req,
  input  logic [15:0] scan_addr,
  output logic        scan_valid,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_RDCAP = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [5:0] CMD_READ  = 6'b010011;
  localparam logic [5:0] CMD_WRITE = 6'b100011;
  localparam logic [5:0] CMD_CLEAR = 6'b110000;

  localparam logic [15:0] LAST_ADDR = 16'(VRAM_WORDS - 1);
  localparam logic [16:0] WORDS_17  = 17'(VRAM_WORDS);

  logic [2:0]  fsm;
  logic [15:0] lat_addr;
  logic [15:0] lat_data;
  logic [15:0] clr_cnt;
  logic        port_free;
  logic        addr_ok;

  // Scanout owns the port whenever it asks; the FSM only moves on free cycles.
  assign port_free = ~scan_req;
  // Compare in 17 bits so the full 16-bit address space never wraps.
  assign addr_ok   = ({1'b0, lat_addr} < WORDS_17);

  // Command sequencing, read capture and scanout-valid pipeline.
  // NOTE: all state here uses <= so every register samples pre-edge values;
  // blocking assignments would make ordering between these lines matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= S_IDLE;
      lat_addr   <= '0;
      lat_data   <= '0;
      clr_cnt    <= '0;
      rd_data    <= '0;
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= scan_req;
      case (fsm)
        S_IDLE: begin
          if (cmd == CMD_READ || cmd == CMD_WRITE || cmd == CMD_CLEAR) begin
            lat_addr <= cmd_addr;
            lat_data <= cmd_data;
            case (cmd)
              CMD_READ:  fsm <= S_READ;
              CMD_WRITE: fsm <= S_WRITE;
              default:   fsm <= S_CLEAR;
            endcase
          end
        end
        S_READ: begin
          if (port_free) fsm <= S_RDCAP;
        end
        S_RDCAP: begin
          // Data belongs to the previous access, so scanout this cycle is irrelevant.
          rd_data <= addr_ok ? ram_rdata : 16'h0000;
          fsm     <= S_DONE;
        end
        S_WRITE: begin
          if (port_free) fsm <= S_DONE;
        end
        S_CLEAR: begin
          if (port_free) begin
            if (clr_cnt == LAST_ADDR) begin
              clr_cnt <= '0;
              fsm     <= S_DONE;
            end else begin
              clr_cnt <= clr_cnt + 16'd1;
            end
          end
        end
        S_DONE: begin
          if (cmd == 6'd0) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // RAM port mux: scanout first, otherwise whatever the FSM needs this cycle.
  // NOTE: every output gets a default before the branches so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (rst) begin
      ram_we = 1'b0;
    end else if (scan_req) begin
      ram_addr = scan_addr;
    end else begin
      case (fsm)
        S_READ: ram_addr = lat_addr;
        S_WRITE: begin
          ram_addr  = lat_addr;
          ram_wdata = lat_data;
          ram_we    = addr_ok;
        end
        S_CLEAR: begin
          ram_addr  = clr_cnt;
          ram_wdata = {lat_data[15:8], FILL_CHAR};
          ram_we    = 1'b1;
        end
        default: ram_addr = '0;
      endcase
    end
  end

  // Status encoding seen by the control block; 11 is unreachable.
  always_comb begin
    case (fsm)
      S_IDLE:  state = 2'b00;
      S_DONE:  state = 2'b10;
      default: state = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_vram_sequencer.sv
// Scoreboard bench for vram_sequencer with a behavioural 1-cycle-latency VRAM.
module tb_vram_sequencer;

  localparam int         VW        = 2400;
  localparam logic [5:0] CMD_READ  = 6'b010011;
  localparam logic [5:0] CMD_WRITE = 6'b100011;
  localparam logic [5:0] CMD_CLEAR = 6'b110000;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [5:0]  cmd;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [15:0] rd_data;
  logic [1:0]  state;
  logic        scan_req;
  logic [15:0] scan_addr;
  logic        scan_valid;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  wr_t         mon_e;
  logic        prev_req;
  logic        oor_wr;
  logic [15:0] mem [0:VW-1];

  vram_sequencer #(.VRAM_WORDS(VW), .FILL_CHAR(8'h20)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rd_data    (rd_data),
    .state      (state),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_valid (scan_valid),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // VRAM model: synchronous write, registered read; out-of-range writes flagged.
  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_addr < 16'(VW)) mem[ram_addr] <= ram_wdata;
      else oor_wr <= 1'b1;
    end
    ram_rdata <= (ram_addr < 16'(VW)) ? mem[ram_addr] : 16'hDEAD;
  end

  // Monitor: every RAM write is matched against the scoreboard; scanout checked.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexp_we", {16'h0, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", {16'h0, ram_addr}, {16'h0, mon_e.addr});
          chk("wr_data", {16'h0, ram_wdata}, {16'h0, mon_e.data});
        end
      end
      if (scan_req) begin
        chk("scan_addr", {16'h0, ram_addr}, {16'h0, scan_addr});
        chk("scan_we", {31'h0, ram_we}, 32'h0);
      end
      chk("scan_valid", {31'h0, scan_valid}, {31'h0, prev_req});
      chk("state_not11", {31'h0, (state == 2'b11)}, 32'h0);
    end
    prev_req = rst ? 1'b0 : scan_req;
  end

  // Issue one command, optionally stall it with scanout, check timing and results.
  task automatic do_cmd(input string tag, input logic [5:0] c, input logic [15:0] a,
                        input logic [15:0] d, input int stall, input int exp_lat,
                        input int exp_we_n, input logic [15:0] rd_exp);
    int n;
    int we_n;
    int sv;
    logic [15:0] rv;
    @(posedge clk); #1;
    cmd = c; cmd_addr = a; cmd_data = d;
    if (c == CMD_WRITE && a < 16'(VW)) exp_wr.push_back('{addr: a, data: d});
    if (c == CMD_READ) exp_rd.push_back(rd_exp);
    if (c == CMD_CLEAR)
      for (int i = 0; i < VW; i++) exp_wr.push_back('{addr: 16'(i), data: {d[15:8], 8'h20}});
    @(posedge clk); #1;  // command latched at this edge
    cmd_addr  = ~a;      // changes while busy must be ignored
    cmd_data  = ~d;
    scan_req  = (stall > 0);
    scan_addr = 16'h0123;
    n = 0; we_n = -1; sv = 0;
    forever begin
      @(negedge clk);
      n++;
      if (ram_we && we_n < 0) we_n = n;
      if (scan_valid) sv++;
      if (n == 1) chk({tag, "_busy"}, {30'h0, state}, 32'h1);
      if (state == 2'b10) break;
      if (n > exp_lat + 5) break;
      @(posedge clk); #1;
      if (n >= stall) scan_req = 1'b0;
    end
    scan_req = 1'b0;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_we_cycle"}, we_n, exp_we_n);
    chk({tag, "_scan_pulses"}, sv, stall);
    if (c == CMD_READ) begin
      rv = exp_rd.pop_front();
      chk({tag, "_rd_data"}, {16'h0, rd_data}, {16'h0, rv});
    end
    cmd = 6'd0;
    @(negedge clk);
    chk({tag, "_idle"}, {30'h0, state}, 32'h0);
    if (c == CMD_READ) chk({tag, "_rd_hold"}, {16'h0, rd_data}, {16'h0, rv});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd = '0; cmd_addr = '0; cmd_data = '0;
    scan_req = 1'b0; scan_addr = '0; oor_wr = 1'b0; prev_req = 1'b0;
    for (int i = 0; i < VW; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_state", {30'h0, state}, 32'h0);
    chk("rst_we", {31'h0, ram_we}, 32'h0);
    chk("rst_addr", {16'h0, ram_addr}, 32'h0);
    chk("rst_wdata", {16'h0, ram_wdata}, 32'h0);
    chk("rst_rd", {16'h0, rd_data}, 32'h0);
    chk("rst_sv", {31'h0, scan_valid}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    do_cmd("wr5",    CMD_WRITE, 16'd5,    16'h7041, 0, 2,    1,  16'h0);
    do_cmd("rd5",    CMD_READ,  16'd5,    16'h0000, 0, 3,    -1, 16'h7041);
    do_cmd("wr10st", CMD_WRITE, 16'd10,   16'hABCD, 4, 6,    5,  16'h0);
    do_cmd("rd10st", CMD_READ,  16'd10,   16'h0000, 2, 5,    -1, 16'hABCD);
    do_cmd("wr_oor", CMD_WRITE, 16'd2400, 16'h5555, 0, 2,    -1, 16'h0);
    do_cmd("rd_oor", CMD_READ,  16'd2400, 16'h0000, 0, 3,    -1, 16'h0000);

    // Unowned nonzero command is ignored.
    @(posedge clk); #1; cmd = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ignored_state", {30'h0, state}, 32'h0);
    end
    @(posedge clk); #1; cmd = 6'd0;

    do_cmd("clr1", CMD_CLEAR, 16'h0000, 16'h1F00, 0, VW + 1, 1, 16'h0);
    chk("clr1_last", {16'h0, mem[VW-1]}, 32'h1F20);
    chk("clr1_w5", {16'h0, mem[5]}, 32'h1F20);

    // Reset in the middle of a clear.
    @(posedge clk); #1;
    cmd = CMD_CLEAR; cmd_data = 16'h2A00;
    for (int i = 0; i < VW; i++) exp_wr.push_back('{addr: 16'(i), data: 16'h2A20});
    repeat (1001) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", {30'h0, state}, 32'h0);
    chk("mid_rst_we", {31'h0, ram_we}, 32'h0);
    chk("mid_rst_addr", {16'h0, ram_addr}, 32'h0);
    chk("mid_rst_sv", {31'h0, scan_valid}, 32'h0);
    chk("mid_rst_progress", exp_wr.size() < VW - 900 && exp_wr.size() > VW - 1100, 32'h1);
    exp_wr.delete();
    cmd = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_cmd("clr2", CMD_CLEAR, 16'h0000, 16'h4E00, 0, VW + 1, 1, 16'h0);
    chk("clr2_first", {16'h0, mem[0]}, 32'h4E20);

    chk("wr_left", exp_wr.size(), 32'h0);
    chk("oor_written", {31'h0, oor_wr}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
